// File: rtl/bp_me_mem_cmd_arbiter.sv
// rtl/bp_me_mem_cmd_arbiter.sv - round-robin mem_cmd arbiter with in-order response routing
// Define BP_ME_MEM_ARB_FIXED_PRIO_EN for lowest-index fixed-priority grant instead of round-robin.
module bp_me_mem_cmd_arbiter #(
  parameter int num_req_p         = 2,
  parameter int msg_width_p       = 64,
  parameter int max_outstanding_p = 4,
  localparam int lg_num_req_lp    = (num_req_p > 1) ? $clog2(num_req_p) : 1,
  localparam int cnt_width_lp     = $clog2(max_outstanding_p + 1),
  localparam int ptr_width_lp     = (max_outstanding_p > 1) ? $clog2(max_outstanding_p) : 1
) (
  input  logic                             clk_i,
  input  logic                             reset_i,
  input  logic [num_req_p*msg_width_p-1:0] cmd_i,
  input  logic [num_req_p-1:0]             cmd_v_i,
  output logic [num_req_p-1:0]             cmd_ready_o,
  output logic [msg_width_p-1:0]           resp_o,
  output logic [num_req_p-1:0]             resp_v_o,
  input  logic [num_req_p-1:0]             resp_yumi_i,
  output logic [msg_width_p-1:0]           mem_cmd_o,
  output logic                             mem_cmd_v_o,
  input  logic                             mem_cmd_ready_i,
  input  logic [msg_width_p-1:0]           mem_resp_i,
  input  logic                             mem_resp_v_i,
  output logic                             mem_resp_yumi_o,
  output logic [cnt_width_lp-1:0]          outstanding_o,
  output logic                             error_o
);

  logic [lg_num_req_lp-1:0] ids_r [max_outstanding_p];
  logic [ptr_width_lp-1:0]  wr_ptr_r, rd_ptr_r;
  logic [cnt_width_lp-1:0]  count_r;
  logic                     error_r;
  logic [lg_num_req_lp-1:0] grant_id, head_id;
  logic                     found, full, empty, cmd_hs, resp_hs, resp_live;
  int                       idx;

  assign full  = (count_r == cnt_width_lp'(max_outstanding_p));
  assign empty = (count_r == '0);

`ifdef BP_ME_MEM_ARB_FIXED_PRIO_EN
  always_comb begin
    grant_id = '0;
    found    = 1'b0;
    idx      = 0;
    for (int i = 0; i < num_req_p; i++) begin
      idx = i;
      if (!found && cmd_v_i[idx]) begin
        found    = 1'b1;
        grant_id = lg_num_req_lp'(idx);
      end
    end
  end
`else
  logic [lg_num_req_lp-1:0] rr_ptr_r;

  // Search starts at the pointer so the last winner drops to lowest priority.
  always_comb begin
    grant_id = '0;
    found    = 1'b0;
    idx      = 0;
    for (int i = 0; i < num_req_p; i++) begin
      idx = (int'(rr_ptr_r) + i) % num_req_p;
      if (!found && cmd_v_i[idx]) begin
        found    = 1'b1;
        grant_id = lg_num_req_lp'(idx);
      end
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i)
      rr_ptr_r <= '0;
    else if (cmd_hs)
      rr_ptr_r <= (grant_id == lg_num_req_lp'(num_req_p - 1)) ? '0 : grant_id + 1'b1;
  end
`endif

  assign mem_cmd_o   = cmd_i[grant_id*msg_width_p +: msg_width_p];
  assign mem_cmd_v_o = found & ~full & ~reset_i;
  assign cmd_hs      = mem_cmd_v_o & mem_cmd_ready_i;

  always_comb begin
    cmd_ready_o = '0;
    cmd_ready_o[grant_id] = found & mem_cmd_ready_i & ~full & ~reset_i;
  end

  assign head_id         = ids_r[rd_ptr_r];
  assign resp_live       = mem_resp_v_i & ~empty & ~reset_i;
  assign resp_o          = mem_resp_i;
  assign mem_resp_yumi_o = resp_live & resp_yumi_i[head_id];
  assign resp_hs         = mem_resp_yumi_o;

  always_comb begin
    resp_v_o = '0;
    resp_v_o[head_id] = resp_live;
  end

  // Id storage needs no reset: entries are only read between a write and its dequeue.
  always_ff @(posedge clk_i) begin
    if (cmd_hs)
      ids_r[wr_ptr_r] <= grant_id;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
      error_r  <= 1'b0;
    end else begin
      if (cmd_hs)
        wr_ptr_r <= (wr_ptr_r == ptr_width_lp'(max_outstanding_p - 1)) ? '0 : wr_ptr_r + 1'b1;
      if (resp_hs)
        rd_ptr_r <= (rd_ptr_r == ptr_width_lp'(max_outstanding_p - 1)) ? '0 : rd_ptr_r + 1'b1;
      if (cmd_hs && !resp_hs)
        count_r <= count_r + 1'b1;
      else if (!cmd_hs && resp_hs)
        count_r <= count_r - 1'b1;
      if (mem_resp_v_i && empty)
        error_r <= 1'b1;
    end
  end

  assign outstanding_o = count_r;
  assign error_o       = error_r;

endmodule

// File: tb/tb_bp_me_mem_cmd_arbiter.sv
// tb/tb_bp_me_mem_cmd_arbiter.sv - directed self-checking bench for bp_me_mem_cmd_arbiter
module tb_bp_me_mem_cmd_arbiter;

  localparam logic [63:0] cmd0_c = 64'h1111_0000_0000_00AA;
  localparam logic [63:0] cmd1_c = 64'h2222_0000_0000_00BB;

  logic          clk_i = 1'b0;
  logic          reset_i;
  logic [127:0]  cmd_i;
  logic [1:0]    cmd_v_i;
  logic [1:0]    cmd_ready_o;
  logic [63:0]   resp_o;
  logic [1:0]    resp_v_o;
  logic [1:0]    resp_yumi_i;
  logic [63:0]   mem_cmd_o;
  logic          mem_cmd_v_o;
  logic          mem_cmd_ready_i;
  logic [63:0]   mem_resp_i;
  logic          mem_resp_v_i;
  logic          mem_resp_yumi_o;
  logic [2:0]    outstanding_o;
  logic          error_o;

  int checks = 0;
  int errors = 0;

  bp_me_mem_cmd_arbiter #(.num_req_p(2), .msg_width_p(64), .max_outstanding_p(4)) dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .cmd_i(cmd_i), .cmd_v_i(cmd_v_i), .cmd_ready_o(cmd_ready_o),
    .resp_o(resp_o), .resp_v_o(resp_v_o), .resp_yumi_i(resp_yumi_i),
    .mem_cmd_o(mem_cmd_o), .mem_cmd_v_o(mem_cmd_v_o), .mem_cmd_ready_i(mem_cmd_ready_i),
    .mem_resp_i(mem_resp_i), .mem_resp_v_i(mem_resp_v_i), .mem_resp_yumi_o(mem_resp_yumi_o),
    .outstanding_o(outstanding_o), .error_o(error_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  logic [1:0]  ord_ids [4] = '{2'b01, 2'b10, 2'b10, 2'b01};
  logic [63:0] ord_dat [4] = '{64'h10, 64'h21, 64'h32, 64'h43};

  initial begin
    reset_i = 1'b1;
    cmd_i = {cmd1_c, cmd0_c};
    cmd_v_i = 2'b11;
    mem_cmd_ready_i = 1'b1;
    mem_resp_v_i = 1'b1;
    mem_resp_i = 64'hA5;
    resp_yumi_i = 2'b11;
    #3;
    check("rst_outstanding", 64'(outstanding_o), 64'd0);
    check("rst_error", 64'(error_o), 64'd0);
    check("rst_mem_cmd_v", 64'(mem_cmd_v_o), 64'd0);
    check("rst_cmd_ready", 64'(cmd_ready_o), 64'd0);
    check("rst_resp_v", 64'(resp_v_o), 64'd0);
    check("rst_mem_resp_yumi", 64'(mem_resp_yumi_o), 64'd0);
    repeat (2) @(posedge clk_i);
    #1;
    reset_i = 1'b0;
    mem_resp_v_i = 1'b0;
    resp_yumi_i = 2'b00;

    // contention: both valid, grants alternate from requester 0 until full
    for (int k = 0; k < 4; k++) begin
      #1;
      check("cont_mem_cmd", mem_cmd_o, (k % 2 == 0) ? cmd0_c : cmd1_c);
      check("cont_ready", 64'(cmd_ready_o), (k % 2 == 0) ? 64'd1 : 64'd2);
      check("cont_outstanding", 64'(outstanding_o), 64'(k));
      step();
    end
    #1;
    check("full_outstanding", 64'(outstanding_o), 64'd4);
    check("full_mem_cmd_v", 64'(mem_cmd_v_o), 64'd0);
    check("full_cmd_ready", 64'(cmd_ready_o), 64'd0);

    // dequeue while full: no full-bypass in the same cycle
    mem_resp_v_i = 1'b1;
    resp_yumi_i = 2'b01;
    #1;
    check("deq_resp_v", 64'(resp_v_o), 64'd1);
    check("deq_resp_o", resp_o, 64'hA5);
    check("deq_mem_resp_yumi", 64'(mem_resp_yumi_o), 64'd1);
    check("nobypass_mem_cmd_v", 64'(mem_cmd_v_o), 64'd0);
    step();
    mem_resp_v_i = 1'b0;
    resp_yumi_i = 2'b00;
    #1;
    check("after_deq_outstanding", 64'(outstanding_o), 64'd3);
    check("after_deq_mem_cmd_v", 64'(mem_cmd_v_o), 64'd1);
    check("after_deq_mem_cmd", mem_cmd_o, cmd0_c);
    step();
    cmd_v_i = 2'b00;
    #1;
    check("refill_outstanding", 64'(outstanding_o), 64'd4);

    // fifo now holds 1,0,1,0; non-head yumi ignored
    mem_resp_v_i = 1'b1;
    resp_yumi_i = 2'b01;
    #1;
    check("nonhead_resp_v", 64'(resp_v_o), 64'd2);
    check("nonhead_yumi", 64'(mem_resp_yumi_o), 64'd0);
    step();
    check("nonhead_outstanding", 64'(outstanding_o), 64'd4);
    resp_yumi_i = 2'b11;
    #1;
    check("head1_yumi", 64'(mem_resp_yumi_o), 64'd1);
    step();
    resp_yumi_i = 2'b10;
    #1;
    check("stall_resp_v", 64'(resp_v_o), 64'd1);
    check("stall_yumi", 64'(mem_resp_yumi_o), 64'd0);
    step();
    check("stall_outstanding", 64'(outstanding_o), 64'd3);
    resp_yumi_i = 2'b11;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("drain_resp_v", 64'(resp_v_o), (k % 2 == 0) ? 64'd1 : 64'd2);
      step();
    end
    mem_resp_v_i = 1'b0;
    #1;
    check("drain_outstanding", 64'(outstanding_o), 64'd0);

    // ordering r0,r1,r1,r0
    for (int k = 0; k < 4; k++) begin
      cmd_v_i = ord_ids[k];
      #1;
      check("ord_mem_cmd", mem_cmd_o, (ord_ids[k] == 2'b01) ? cmd0_c : cmd1_c);
      step();
    end
    cmd_v_i = 2'b00;
    mem_resp_v_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      mem_resp_i = ord_dat[k];
      #1;
      check("ord_resp_v", 64'(resp_v_o), 64'(ord_ids[k]));
      check("ord_resp_o", resp_o, ord_dat[k]);
      step();
    end
    mem_resp_v_i = 1'b0;
    #1;
    check("ord_outstanding", 64'(outstanding_o), 64'd0);
    check("ord_error", 64'(error_o), 64'd0);

    // same-cycle enqueue and dequeue keeps count
    cmd_v_i = 2'b10;
    step();
    cmd_v_i = 2'b01;
    mem_resp_v_i = 1'b1;
    #1;
    check("same_resp_v", 64'(resp_v_o), 64'd2);
    check("same_mem_cmd_v", 64'(mem_cmd_v_o), 64'd1);
    step();
    cmd_v_i = 2'b00;
    #1;
    check("same_outstanding", 64'(outstanding_o), 64'd1);
    check("same_head", 64'(resp_v_o), 64'd1);
    step();
    mem_resp_v_i = 1'b0;
    #1;
    check("same_drained", 64'(outstanding_o), 64'd0);

    // no empty-bypass; response while empty is spurious and sticky
    cmd_v_i = 2'b01;
    mem_resp_v_i = 1'b1;
    #1;
    check("empty_resp_v", 64'(resp_v_o), 64'd0);
    check("empty_yumi", 64'(mem_resp_yumi_o), 64'd0);
    check("empty_error_pre", 64'(error_o), 64'd0);
    step();
    cmd_v_i = 2'b00;
    #1;
    check("empty_next_resp_v", 64'(resp_v_o), 64'd1);
    check("error_set", 64'(error_o), 64'd1);
    step();
    mem_resp_v_i = 1'b0;
    step();
    check("error_sticky", 64'(error_o), 64'd1);
    check("spur_outstanding", 64'(outstanding_o), 64'd0);

    // three outstanding, pointer left at 1, then async reset mid-cycle
    for (int k = 0; k < 3; k++) begin
      cmd_v_i = (k == 1) ? 2'b10 : 2'b01;
      step();
    end
    cmd_v_i = 2'b11;
    mem_cmd_ready_i = 1'b0;
    #1;
    check("pre_rst_outstanding", 64'(outstanding_o), 64'd3);
    check("pre_rst_grant", mem_cmd_o, cmd1_c);
    mem_resp_v_i = 1'b1;
    #1;
    reset_i = 1'b1;
    #1;
    check("arst_outstanding", 64'(outstanding_o), 64'd0);
    check("arst_mem_cmd_v", 64'(mem_cmd_v_o), 64'd0);
    check("arst_cmd_ready", 64'(cmd_ready_o), 64'd0);
    check("arst_resp_v", 64'(resp_v_o), 64'd0);
    check("arst_yumi", 64'(mem_resp_yumi_o), 64'd0);
    check("arst_error", 64'(error_o), 64'd0);
    step();
    reset_i = 1'b0;
    mem_resp_v_i = 1'b0;
    mem_cmd_ready_i = 1'b1;
    #1;
    check("post_rst_grant", mem_cmd_o, cmd0_c);
    check("post_rst_ready", 64'(cmd_ready_o), 64'd1);
    step();
    check("post_rst_next", mem_cmd_o, cmd1_c);
    check("post_rst_outstanding", 64'(outstanding_o), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
